// File: rtl/mem_ctrl_pkg.sv
// Shared constants and state type for the word/byte memory controller.
// Imported by mem_ctrl and its byte_lane helper.
package mem_ctrl_pkg;

    localparam int NBITS = 32;
    localparam int BYTE  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        FETCH = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_ctrl_byte_lane.sv
// Combinational byte select/insert for the lane addressed by cnt.
// Lane order follows BIG_ENDIAN (cnt 0 is the MSB byte when set).
module byte_lane
    import mem_ctrl_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [NBITS-1:0] word_i,
    input  logic [BYTE-1:0]  byte_i,
    input  logic [1:0]       cnt_i,
    output logic [BYTE-1:0]  sel_o,
    output logic [NBITS-1:0] ins_o
);

    logic [1:0] lane;
    int         lsb;

    assign lane = BIG_ENDIAN ? ~cnt_i : cnt_i;
    assign lsb  = int'(lane) * BYTE;

    always_comb begin
        sel_o = word_i[lsb +: BYTE];
        ins_o = word_i;
        ins_o[lsb +: BYTE] = byte_i;
    end

endmodule

// File: rtl/mem_ctrl.sv
// Sequences word reads/writes and byte fetches over a byte-wide
// synchronous memory port, one byte per cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_req,
    input  logic             wr_req,
    input  logic             fetch_req,
    input  logic [NBITS-1:0] mar,
    input  logic [NBITS-1:0] mdr_in,
    input  logic [NBITS-1:0] pc,
    output logic [NBITS-1:0] mdr_out,
    output logic             mdr_valid,
    output logic [BYTE-1:0]  mbr_out,
    output logic             mbr_valid,
    output logic             busy,
    output logic [NBITS-1:0] mem_addr,
    output logic [BYTE-1:0]  mem_out,
    output logic             we,
    input  logic [BYTE-1:0]  mem_in
);

    mem_state_t       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             issue_q, issue_d;
    logic             cap_q, cap_d;
    logic             fpend_q, fpend_d;
    logic [NBITS-3:0] mar_q, mar_d;
    logic [NBITS-1:0] mdr_q, mdr_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] rd_data_q, rd_data_d;
    logic [NBITS-1:0] mdr_out_q, mdr_out_d;
    logic             mdr_valid_q, mdr_valid_d;
    logic [BYTE-1:0]  mbr_out_q, mbr_out_d;
    logic             mbr_valid_q, mbr_valid_d;

    logic [1:0]       lane_cnt;
    logic [NBITS-1:0] lane_word;
    logic [BYTE-1:0]  lane_sel;
    logic [NBITS-1:0] lane_ins;
    logic             unused_mar;

    // Top two word-address bits fall off the byte address.
    assign unused_mar = ^mar[NBITS-1:NBITS-2];

    // Read data for byte cnt-1 arrives while address cnt is on the bus.
    assign lane_cnt  = (state_q == WR) ? cnt_q : cnt_q - 2'd1;
    assign lane_word = (state_q == WR) ? mdr_q : rd_data_q;

    byte_lane #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane (
        .word_i(lane_word),
        .byte_i(mem_in),
        .cnt_i (lane_cnt),
        .sel_o (lane_sel),
        .ins_o (lane_ins)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        issue_d     = issue_q;
        cap_d       = 1'b0;
        fpend_d     = fpend_q;
        mar_d       = mar_q;
        mdr_d       = mdr_q;
        pc_d        = pc_q;
        rd_data_d   = rd_data_q;
        mdr_out_d   = mdr_out_q;
        mdr_valid_d = 1'b0;
        mbr_out_d   = mbr_out_q;
        mbr_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    state_d = wr_req ? WR : RD;
                    issue_d = !wr_req;
                    cnt_d   = 2'd0;
                    mar_d   = mar[NBITS-3:0];
                    mdr_d   = mdr_in;
                    if (fetch_req && !fpend_q) begin
                        fpend_d = 1'b1;
                        pc_d    = pc;
                    end
                end else if (fetch_req || fpend_q) begin
                    state_d = FETCH;
                    cnt_d   = 2'd0;
                    fpend_d = 1'b0;
                    if (!fpend_q) pc_d = pc;
                end
            end
            RD: begin
                cap_d = issue_q;
                if (issue_q) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) issue_d = 1'b0;
                end
                if (cap_q) begin
                    rd_data_d = lane_ins;
                    if (!issue_q) begin
                        mdr_out_d   = lane_ins;
                        mdr_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            WR: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = IDLE;
            end
            FETCH: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd1) begin
                    mbr_out_d   = mem_in;
                    mbr_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && fetch_req && !fpend_q) begin
            fpend_d = 1'b1;
            pc_d    = pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            issue_q     <= 1'b0;
            cap_q       <= 1'b0;
            fpend_q     <= 1'b0;
            mar_q       <= '0;
            mdr_q       <= '0;
            pc_q        <= '0;
            rd_data_q   <= '0;
            mdr_out_q   <= '0;
            mdr_valid_q <= 1'b0;
            mbr_out_q   <= '0;
            mbr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            issue_q     <= issue_d;
            cap_q       <= cap_d;
            fpend_q     <= fpend_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            pc_q        <= pc_d;
            rd_data_q   <= rd_data_d;
            mdr_out_q   <= mdr_out_d;
            mdr_valid_q <= mdr_valid_d;
            mbr_out_q   <= mbr_out_d;
            mbr_valid_q <= mbr_valid_d;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_out  = '0;
        we       = 1'b0;
        unique case (state_q)
            RD:    if (issue_q) mem_addr = {mar_q, cnt_q};
            WR: begin
                mem_addr = {mar_q, cnt_q};
                mem_out  = lane_sel;
                we       = 1'b1;
            end
            FETCH: if (cnt_q == 2'd0) mem_addr = pc_q;
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign mdr_out   = mdr_out_q;
    assign mdr_valid = mdr_valid_q;
    assign mbr_out   = mbr_out_q;
    assign mbr_valid = mbr_valid_q;

endmodule
